// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared Hack CPU types and instruction field positions
package hack_pkg;

   typedef enum logic {RUN, WR} state_t;

   localparam int C_A  = 12;
   localparam int C_ZX = 11;
   localparam int C_NX = 10;
   localparam int C_ZY = 9;
   localparam int C_NY = 8;
   localparam int C_F  = 7;
   localparam int C_NO = 6;
   localparam int C_DA = 5;
   localparam int C_DD = 4;
   localparam int C_DM = 3;
   localparam int J_LT = 2;
   localparam int J_EQ = 1;
   localparam int J_GT = 0;

endpackage

// File: rtl/hack_alu_p.sv
// rtl/hack_alu_p.sv - parametrised combinational Hack ALU with zero/negative flags
module hack_alu_p #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic              zx,
   input  logic              nx,
   input  logic              zy,
   input  logic              ny,
   input  logic              f,
   input  logic              no,
   output logic [DATA_W-1:0] out,
   output logic              zr,
   output logic              ng
);

   logic [DATA_W-1:0] x_z, x_n, y_z, y_n, f_out;

   assign x_z   = zx ? '0 : x;
   assign x_n   = nx ? ~x_z : x_z;
   assign y_z   = zy ? '0 : y;
   assign y_n   = ny ? ~y_z : y_z;
   assign f_out = f ? (x_n + y_n) : (x_n & y_n);
   assign out   = no ? ~f_out : f_out;
   assign zr    = (out == '0);
   assign ng    = out[DATA_W-1];

endmodule

// File: rtl/hack_cpu_hs.sv
// rtl/hack_cpu_hs.sv - Hack CPU core with handshaked ROM/RAM access and sequenced read-modify-write
module hack_cpu_hs #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 15,
   parameter int PC_W   = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] instr,
   input  logic              instr_valid,
   output logic [PC_W-1:0]   pc,
   input  logic [DATA_W-1:0] in_m,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] out_m,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic              mem_ack,
   output logic              retire,
   output logic              stall
);

   import hack_pkg::*;

   state_t            state, state_nx;
   logic [DATA_W-1:0] a_reg, d_reg, m_lat, ir_q, ir, y, alu_out;
   logic [PC_W-1:0]   pc_q;
   logic              zr, ng, is_c, taken, commit, rd_c, wr_c, latch_rd;
   logic              unused_bits;

   // During the write half of a read-modify-write the instruction comes from the internal copy
   assign ir          = (state == WR) ? ir_q : instr;
   assign is_c        = ir[DATA_W-1];
   assign y           = (state == WR) ? m_lat : (ir[C_A] ? in_m : a_reg);
   assign unused_bits = ^ir[DATA_W-2:C_A+1];

   hack_alu_p #(.DATA_W(DATA_W)) u_alu (
      .x   (d_reg),
      .y   (y),
      .zx  (ir[C_ZX]),
      .nx  (ir[C_NX]),
      .zy  (ir[C_ZY]),
      .ny  (ir[C_NY]),
      .f   (ir[C_F]),
      .no  (ir[C_NO]),
      .out (alu_out),
      .zr  (zr),
      .ng  (ng)
   );

   assign taken = is_c & ((ir[J_LT] & ng) | (ir[J_EQ] & zr) | (ir[J_GT] & ~zr & ~ng));

   always_comb begin
      state_nx = state;
      rd_c     = 1'b0;
      wr_c     = 1'b0;
      commit   = 1'b0;
      latch_rd = 1'b0;
      case (state)
         RUN: begin
            if (instr_valid) begin
               if (!is_c) begin
                  commit = 1'b1;
               end else if (ir[C_A]) begin
                  rd_c = 1'b1;
                  if (mem_ack) begin
                     if (ir[C_DM]) begin
                        latch_rd = 1'b1;
                        state_nx = WR;
                     end else begin
                        commit = 1'b1;
                     end
                  end
               end else if (ir[C_DM]) begin
                  wr_c   = 1'b1;
                  commit = mem_ack;
               end else begin
                  commit = 1'b1;
               end
            end
         end
         WR: begin
            wr_c = 1'b1;
            if (mem_ack) begin
               commit   = 1'b1;
               state_nx = RUN;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         a_reg <= '0;
         d_reg <= '0;
         pc_q  <= '0;
         m_lat <= '0;
         ir_q  <= '0;
      end else begin
         state <= state_nx;
         if (latch_rd) begin
            m_lat <= in_m;
            ir_q  <= ir;
         end
         // A, D and pc all see pre-commit values; the jump target is the old A
         if (commit) begin
            pc_q <= taken ? a_reg[PC_W-1:0] : pc_q + PC_W'(1);
            if (is_c && ir[C_DD]) d_reg <= alu_out;
            if (!is_c)            a_reg <= ir;
            else if (ir[C_DA])    a_reg <= alu_out;
         end
      end
   end

   // Reset drops any outstanding request in the same cycle
   assign mem_rd   = rd_c & ~reset;
   assign mem_wr   = wr_c & ~reset;
   assign retire   = commit & ~reset;
   assign stall    = instr_valid & ~retire & ~reset;
   assign pc       = pc_q;
   assign mem_addr = a_reg[ADDR_W-1:0];
   assign out_m    = alu_out;

endmodule

// File: tb/tb_hack_cpu_hs.sv
// tb/tb_hack_cpu_hs.sv - self-checking bench for hack_cpu_hs against an instruction-level model
module tb_hack_cpu_hs;

   logic        clk, reset, instr_valid, mem_rd, mem_wr, mem_ack, retire, stall;
   logic [15:0] instr, in_m, out_m;
   logic [14:0] pc, mem_addr;

   hack_cpu_hs dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .pc(pc),
      .in_m(in_m), .mem_addr(mem_addr), .out_m(out_m), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_ack(mem_ack), .retire(retire), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rd_cnt, wr_cnt, ret_cnt;
   logic [15:0] last_out;
   logic [14:0] last_addr;

   logic [15:0] rom [0:32767];
   logic [15:0] m_a, m_d, m_lat, m_ir;
   logic [14:0] m_pc;
   logic        m_phase;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] alu_model(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
      logic [15:0] xx, yy, o;
      xx = c[5] ? 16'd0 : x;
      if (c[4]) xx = 16'hFFFF - xx;
      yy = c[3] ? 16'd0 : y;
      if (c[2]) yy = 16'hFFFF - yy;
      o = c[1] ? xx + yy : xx & yy;
      if (c[0]) o = 16'hFFFF - o;
      return o;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_retire", retire, 0);
      check("rst_stall", stall, 0);
      check("rst_pc", pc, 0);
      check("rst_addr", mem_addr, 0);
      instr_valid = 1'b0;
      mem_ack     = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      m_a = 0; m_d = 0; m_pc = 0; m_phase = 0; m_lat = 0; m_ir = 0;
   endtask

   // One clock: drive inputs, compare every output against the model, then advance the model
   task automatic step(input logic v, input logic ack, input logic [15:0] din);
      logic [15:0] ir, y, r;
      logic        e_rd, e_wr, com, ng, zr, tk;
      @(negedge clk);
      instr_valid = v;
      mem_ack     = ack;
      in_m        = din;
      instr       = m_phase ? 16'($urandom) : rom[m_pc];
      #1;
      ir   = m_phase ? m_ir : instr;
      y    = m_phase ? m_lat : (ir[12] ? din : m_a);
      r    = alu_model(m_d, y, ir[11:6]);
      e_rd = 1'b0; e_wr = 1'b0; com = 1'b0;
      if (m_phase) begin
         e_wr = 1'b1;
         com  = ack;
      end else if (v) begin
         if (!ir[15]) com = 1'b1;
         else begin
            e_rd = ir[12];
            e_wr = !ir[12] && ir[3];
            com  = (e_rd || e_wr) ? ack : 1'b1;
            if (e_rd && ir[3]) com = 1'b0;
         end
      end
      check("pc", pc, m_pc);
      check("mem_addr", mem_addr, m_a[14:0]);
      check("mem_rd", mem_rd, e_rd);
      check("mem_wr", mem_wr, e_wr);
      check("retire", retire, com);
      check("stall", stall, v && !com);
      if (e_wr) check("out_m", out_m, r);
      last_out  = out_m;
      last_addr = mem_addr;
      rd_cnt  += int'(mem_rd);
      wr_cnt  += int'(mem_wr);
      ret_cnt += int'(retire);
      @(posedge clk);
      #1;
      if (com) begin
         ng = r[15];
         zr = (r == 16'd0);
         tk = ir[15] && ((ir[2] && ng) || (ir[1] && zr) || (ir[0] && !zr && !ng));
         m_pc = tk ? m_a[14:0] : m_pc + 15'd1;
         if (ir[15] && ir[4]) m_d = r;
         m_a = !ir[15] ? ir : (ir[5] ? r : m_a);
         m_phase = 1'b0;
      end else if (!m_phase && v && ir[15] && ir[12] && ir[3] && ack) begin
         m_phase = 1'b1;
         m_lat   = din;
         m_ir    = ir;
      end
   endtask

   task automatic clr_cnt();
      rd_cnt = 0; wr_cnt = 0; ret_cnt = 0;
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; in_m = 16'd0; instr = 16'd0;
      for (int i = 0; i < 32768; i++) rom[i] = 16'hEA90;
      rom[0]  = 16'h0005; rom[1]  = 16'hEC10; rom[2]  = 16'h0007; rom[3]  = 16'hE090;
      rom[4]  = 16'h0000; rom[5]  = 16'hE308; rom[6]  = 16'h0003; rom[7]  = 16'hFDC8;
      rom[8]  = 16'hEE90; rom[9]  = 16'h0014; rom[10] = 16'hE304;
      rom[20] = 16'hEA90; rom[21] = 16'h001E; rom[22] = 16'hE301; rom[23] = 16'hE302;
      rom[30] = 16'h0028; rom[31] = 16'hFC02;
      rom[40] = 16'h0032; rom[41] = 16'hFCAA;
      rom[50] = 16'h7FFF; rom[51] = 16'hEA87; rom[32767] = 16'hEA90;
      clr_cnt();
      do_reset();

      // zero-wait straight-line program ending in M=D
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 16'($urandom));
      check("t2_out_m", last_out, 16'd12);
      check("t2_addr", last_addr, 15'd0);
      check("t2_pc", pc, 15'd6);
      check("t2_model_d", m_d, 16'd12);

      // M=M+1 with a 2-cycle read wait and a 1-cycle write wait
      step(1'b1, 1'b1, 16'd0);
      clr_cnt();
      step(1'b1, 1'b0, 16'd41);
      step(1'b1, 1'b0, 16'd41);
      step(1'b1, 1'b1, 16'd41);
      step(1'b0, 1'b0, 16'($urandom));
      step(1'b1, 1'b1, 16'($urandom));
      check("t3_rd_cycles", rd_cnt, 3);
      check("t3_wr_cycles", wr_cnt, 2);
      check("t3_retires", ret_cnt, 1);
      check("t3_out_m", last_out, 16'd42);
      check("t3_pc", pc, 15'd8);

      // jumps
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'd0);
      check("t4_jlt", pc, 15'd20);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'd0);
      check("t4_jgt_not", pc, 15'd23);
      step(1'b1, 1'b1, 16'd0);
      check("t4_jeq", pc, 15'd30);
      step(1'b1, 1'b1, 16'd0);
      clr_cnt();
      step(1'b1, 1'b0, 16'd0);
      step(1'b1, 1'b1, 16'd0);
      check("t4_ack_commit", ret_cnt, 1);
      check("t4_m_jeq", pc, 15'd40);

      // idle cycles, then AM=M-1;JEQ
      clr_cnt();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'd0);
      check("t5_idle_retire", ret_cnt, 0);
      check("t5_idle_pc", pc, 15'd40);
      step(1'b1, 1'b1, 16'd0);
      step(1'b1, 1'b1, 16'd1);
      step(1'b1, 1'b1, 16'($urandom));
      check("t6_wr_addr", last_addr, 15'd50);
      check("t6_out_m", last_out, 16'd0);
      check("t6_pc", pc, 15'd50);
      check("t6_a", mem_addr, 15'd0);

      // pc wrap
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'd0);
      check("t5_wrap", pc, 15'd0);

      // reset in the write half of a read-modify-write
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 16'd0);
      step(1'b1, 1'b1, 16'd41);
      step(1'b1, 1'b0, 16'd0);
      check("t1_wr_before", last_addr, 15'd3);
      do_reset();
      check("t1_model_d", m_d, 16'd0);

      // randomised programs and handshakes
      for (int i = 0; i < 32768; i++) begin
         logic [31:0] r;
         r = $urandom;
         if (r[1:0] == 2'd0) rom[i] = {1'b0, 10'd0, r[8:4]};
         else if (r[1:0] == 2'd1 && r[2]) rom[i] = {1'b0, r[18:4]};
         else rom[i] = {1'b1, r[30:16]};
      end
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         step($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, 16'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hack_cpu_hs.md
Name: hack_cpu_hs

Overview:
Parametrised next-generation Hack CPU core with the standard A/D/PC datapath and Hack instruction set. Data memory and instruction ROM are reached through request/acknowledge handshakes, so slow RAM and slow ROM are supported. The core stalls until each access completes. Read-modify-write C-instructions (e.g. M=M+1) run as a sequenced read-then-write. Sits between the instruction ROM and the data RAM/memory-mapped I/O in the Computer top level.

Parameters:
DATA_W, 16, data/instruction width; minimum 16; C-instruction fields occupy bits [12:0] plus the MSB.
ADDR_W, 15, data address width taken from A[ADDR_W-1:0].
PC_W, 15, program counter width; pc wraps modulo 2^PC_W.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
instr  in  DATA_W  instruction at address pc; held stable by ROM while pc unchanged.
instr_valid  in  1  instr is valid this cycle.
pc  out  PC_W  ROM address of current instruction.
in_m  in  DATA_W  read data, valid when mem_ack=1 during a read.
mem_addr  out  ADDR_W  A register low bits.
out_m  out  DATA_W  ALU result / write data.
mem_rd  out  1  read request, level, held until mem_ack.
mem_wr  out  1  write request, level, held with out_m/mem_addr stable until mem_ack.
mem_ack  in  1  completes the current mem_rd or mem_wr this cycle.
retire  out  1  one-cycle pulse: instruction committed this cycle.
stall  out  1  valid instruction present but not committed this cycle.

Behaviour:
- Reset (async, high): A=0, D=0, pc=0, m_lat=0, state=RUN. While reset is high, mem_rd=mem_wr=retire=stall=0 (combinationally gated).
- Decode:
  - A-instr: instr[DATA_W-1]=0.
  - C-instr fields: a=instr[12], zx..no=instr[11:6], dA/dD/dM=instr[5:3], j lt/eq/gt=instr[2:0].
  - Upper bits between MSB and bit 12 are ignored.
- ALU: standard Hack ALU at DATA_W. x=D; y=(a ? M : A). zr = (out==0); ng = out[DATA_W-1].
- Jump taken = C & ((lt&ng) | (eq&zr) | (gt&!zr&!ng)). Commit sets pc = taken ? A_old[PC_W-1:0] : pc+1.
- Commit semantics: A, D and pc all update on the same edge using pre-commit A and D values. A gets the ALU result if dA, or instr if A-instr.
- States:
  - RUN: the idle/issue state.
    - No commit while instr_valid=0.
    - A-instr, or C with a=0 and dM=0: commit in 1 cycle.
    - C with a=1: mem_rd=1. On mem_ack: if dM=1, latch m_lat=in_m and go to WR; else commit using in_m.
    - C with a=0 and dM=1: mem_wr=1. On mem_ack, commit; otherwise stay.
  - WR: ALU y=m_lat; mem_wr=1. On mem_ack, commit and return to RUN.
- Latency (zero-wait memory, ack same cycle): A/plain-C 1 cycle; read-only C 1; write-only C 1; read-modify-write 2. Each cycle without ack adds 1.
- mem_rd and mem_wr are never high together. Requests are combinational from state and instr.
- instr_valid dropping while in WR has no effect; instr is held internally for the remainder of the instruction.
- mem_ack with no request pending is ignored.
- Reset during WAIT/WR abandons the access immediately: no register commit, and the request drops in the same cycle.
- pc+1 at 2^PC_W-1 wraps to 0.
- retire=1 exactly on the commit cycle. stall = instr_valid & !retire & !reset.

Decomposition:
- Shared package hack_pkg: state enum (RUN, WR); C-field bit-index constants; jump-bit constants.
- One sub-module: hack_alu_p (parametrised DATA_W combinational ALU with zr/ng).
- Decode, FSM and registers stay in hack_cpu_hs.

Test Plan:
1. Reset sequence: reset high mid-write with mem_wr=1 -> mem_wr=0 immediately; after release pc=0, A=0, D=0.
2. Zero-wait memory, program @5;D=A;@7;D=D+A;@0;M=D -> retire every cycle; write completes with mem_addr=0, out_m=12, mem_wr for 1 cycle; pc=6.
3. M=M+1 at A=3, in_m=41, ack delayed 2 cycles on the read and 1 on the write -> mem_rd high 3 cycles, then mem_wr with out_m=42 for 2 cycles; retire once; total 5 cycles.
4. Jumps: D=-1 with D;JLT to A=20 -> pc=20. D=0 with D;JGT -> pc+1. D=0 with D;JEQ -> taken. Each commit occurs on the ack cycle for the a=1 variant.
5. instr_valid low for 3 cycles -> pc held, no retire, stall=0. pc at 32767 with plain C -> pc wraps to 0.
6. AM=M-1 with in_m=1 -> A=0 and M written 0 at the old address; zr=1 path with JEQ taken uses A_old.
